// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM capture block.
package pwm_pkg;

  localparam int unsigned PWM_N_DEFAULT = 8;

  typedef logic [1:0] pwm_state_t;

  localparam pwm_state_t ST_IDLE = 2'd0;
  localparam pwm_state_t ST_HIGH = 2'd1;
  localparam pwm_state_t ST_LOW  = 2'd2;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input plus rise/fall
// detection against a third registered copy.
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_c  = sync2_q & ~sync3_q;
  assign fall_c  = ~sync2_q & sync3_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and rise-to-rise period of an asynchronous
// PWM input and flags inputs stuck low or high for a full nominal period.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned n = PWM_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [n-1:0] duty_out,
  output logic [n:0]   period_out,
  output logic         duty_valid,
  output logic         stuck_low,
  output logic         stuck_high
);

  localparam int unsigned CW = n + 1;
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {n{1'b0}}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
  endfunction

  logic level;
  logic rise;
  logic fall;

  pwm_sync_edge u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .pwm_i  (pwm_in),
    .level_o(level),
    .rise_c (rise),
    .fall_c (fall)
  );

  pwm_state_t    state_q, state_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] low_q, low_d;
  logic [n-1:0]  duty_q, duty_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          stuck_low_q, stuck_low_d;
  logic          stuck_high_q, stuck_high_d;

  logic [CW-1:0] per_inc;
  logic [CW-1:0] high_inc;
  logic [CW-1:0] low_inc;

  assign per_inc  = sat_inc(per_q);
  assign high_inc = sat_inc(high_q);
  assign low_inc  = sat_inc(low_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      per_q        <= '0;
      high_q       <= '0;
      low_q        <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      high_q       <= high_d;
      low_q        <= low_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    high_d       = high_q;
    low_d        = low_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_low_d  = stuck_low_q;
    stuck_high_d = stuck_high_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_HIGH;
          per_d       = CW'(1);
          high_d      = CW'(1);
          low_d       = '0;
          stuck_low_d = 1'b0;
        end else if (!level) begin
          low_d = low_inc;
        end
      end
      ST_HIGH: begin
        per_d = per_inc;
        if (fall) begin
          state_d = ST_LOW;
          low_d   = CW'(1);
        end else begin
          high_d = high_inc;
          if (high_inc == CNT_MAX) begin
            stuck_high_d = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          per_d   = CW'(1);
          high_d  = CW'(1);
          low_d   = '0;
          // A period that contained a stuck condition is not a valid measurement
          if (!stuck_low_q && !stuck_high_q) begin
            duty_d   = high_q[n-1:0];
            period_d = per_q;
            valid_d  = 1'b1;
          end
          stuck_low_d  = 1'b0;
          stuck_high_d = 1'b0;
        end else begin
          per_d = per_inc;
          low_d = low_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stuck-low reports a single 0% measurement, shared by IDLE and LOW
    if (state_q != ST_HIGH && !rise && !level && !stuck_low_q && low_inc == CNT_MAX) begin
      stuck_low_d = 1'b1;
      duty_d      = '0;
      period_d    = CNT_MAX;
      valid_d     = 1'b1;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign duty_valid = valid_q;
  assign stuck_low  = stuck_low_q;
  assign stuck_high = stuck_high_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: vector table, hand-built corner sequences and
// random waveforms checked every cycle against a timestamp-based model.
module tb_pwm_capture;

  localparam int unsigned N = 8;
  localparam int P = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pwm_in = 1'b0;
  logic [N-1:0] duty_out;
  logic [N:0]   period_out;
  logic         duty_valid;
  logic         stuck_low;
  logic         stuck_high;

  int n_cmp = 0;
  int n_err = 0;

  pwm_capture #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .period_out(period_out),
    .duty_valid(duty_valid),
    .stuck_low (stuck_low),
    .stuck_high(stuck_high)
  );

  always #5 clk = ~clk;

  // Reference model: works on the synchronized level and edge timestamps
  int           cyc;
  logic         m_d1, m_d2, m_prev;
  bit           have_rise, m_sl, m_sh, m_valid;
  int           rise_t, fall_t, last_one;
  logic [N-1:0] m_duty;
  logic [N:0]   m_per;

  int seen_d[$];
  int seen_p[$];

  typedef struct {
    int duty;
    int plen;
    int periods;
    int exp_duty;
    int exp_period;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int q_at(input int idx, input bit per);
    if (idx >= seen_d.size()) return -1;
    return per ? seen_p[idx] : seen_d[idx];
  endfunction

  task automatic model_reset();
    cyc = 0; m_d1 = 1'b0; m_d2 = 1'b0; m_prev = 1'b0;
    have_rise = 0; m_sl = 0; m_sh = 0; m_valid = 0;
    rise_t = 0; fall_t = 0; last_one = -1;
    m_duty = '0; m_per = '0;
  endtask

  task automatic model_cycle(input logic pin);
    logic s;
    s = m_d2;
    m_valid = 0;
    if (s && !m_prev) begin
      if (have_rise && !m_sl && !m_sh) begin
        m_duty  = N'(fall_t - rise_t);
        m_per   = (cyc - rise_t >= P) ? (N+1)'(P) : (N+1)'(cyc - rise_t);
        m_valid = 1;
      end
      have_rise = 1; rise_t = cyc; m_sl = 0; m_sh = 0;
    end
    if (!s && m_prev) fall_t = cyc;
    if (s) begin
      last_one = cyc;
      if (cyc - rise_t + 1 == P) m_sh = 1;
    end else if (cyc - last_one == P && !m_sl) begin
      m_sl = 1; m_duty = '0; m_per = (N+1)'(P); m_valid = 1;
    end
    m_prev = s; m_d2 = m_d1; m_d1 = pin; cyc++;
  endtask

  task automatic step(input logic rst, input logic pin);
    reset = rst;
    pwm_in = pin;
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else model_cycle(pin);
    check("cyc_outputs",
          32'({duty_valid, stuck_low, stuck_high, duty_out, period_out}),
          32'({m_valid, m_sl, m_sh, m_duty, m_per}));
    if (duty_valid === 1'b1) begin
      seen_d.push_back(int'(duty_out));
      seen_p.push_back(int'(period_out));
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, pwm_in);
    seen_d.delete();
    seen_p.delete();
  endtask

  task automatic gen(input int duty, input int plen, input int periods);
    for (int k = 0; k < periods; k++)
      for (int i = 0; i < plen; i++) step(1'b1, (i < duty) ? 1'b1 : 1'b0);
  endtask

  task automatic trail();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    vecs[0] = '{64, 256, 3, 64, 256};
    vecs[1] = '{128, 256, 2, 128, 256};
    vecs[2] = '{1, 256, 3, 1, 256};
    vecs[3] = '{255, 256, 2, 255, 256};
    vecs[4] = '{10, 50, 3, 10, 50};
    vecs[5] = '{200, 400, 2, 200, 256};

    model_reset();
    pwm_in = 1'b1;
    do_reset();
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_period", 32'(period_out), 32'd0);
    check("rst_valid", 32'(duty_valid), 32'd0);
    check("rst_stuck_low", 32'(stuck_low), 32'd0);
    check("rst_stuck_high", 32'(stuck_high), 32'd0);

    for (int v = 0; v < 6; v++) begin
      pwm_in = 1'b0;
      do_reset();
      gen(vecs[v].duty, vecs[v].plen, vecs[v].periods);
      trail();
      check("vec_valid_count", 32'(seen_d.size()), 32'(vecs[v].periods));
      check("vec_duty", 32'(q_at(vecs[v].periods - 1, 0)), 32'(vecs[v].exp_duty));
      check("vec_period", 32'(q_at(vecs[v].periods - 1, 1)), 32'(vecs[v].exp_period));
    end

    // Duty change at a period boundary
    pwm_in = 1'b0;
    do_reset();
    gen(128, 256, 2);
    gen(192, 256, 2);
    trail();
    check("chg_count", 32'(seen_d.size()), 32'd4);
    check("chg_d0", 32'(q_at(0, 0)), 32'd128);
    check("chg_d1", 32'(q_at(1, 0)), 32'd128);
    check("chg_d2", 32'(q_at(2, 0)), 32'd192);
    check("chg_d3", 32'(q_at(3, 0)), 32'd192);

    // Held low after reset
    pwm_in = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    check("sl_flag", 32'(stuck_low), 32'd1);
    check("sl_count", 32'(seen_d.size()), 32'd1);
    check("sl_duty", 32'(q_at(0, 0)), 32'd0);
    check("sl_period", 32'(q_at(0, 1)), 32'd256);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    check("sl_no_repeat", 32'(seen_d.size()), 32'd1);
    gen(64, 256, 2);
    trail();
    check("sl_cleared", 32'(stuck_low), 32'd0);
    check("sl_after_count", 32'(seen_d.size()), 32'd3);
    check("sl_after_duty", 32'(q_at(1, 0)), 32'd64);

    // Held high for 300 cycles, then normal duty 64
    pwm_in = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    check("sh_flag", 32'(stuck_high), 32'd1);
    check("sh_no_valid", 32'(seen_d.size()), 32'd0);
    gen(64, 256, 1);
    check("sh_held", 32'(stuck_high), 32'd1);
    gen(64, 256, 2);
    trail();
    check("sh_cleared", 32'(stuck_high), 32'd0);
    check("sh_count", 32'(seen_d.size()), 32'd2);
    check("sh_duty", 32'(q_at(0, 0)), 32'd64);

    // Reset asserted in the middle of a high phase at duty 128
    pwm_in = 1'b0;
    do_reset();
    gen(128, 256, 2);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1);
    for (int i = 64; i < 200; i++) step(1'b0, (i < 128) ? 1'b1 : 1'b0);
    check("mid_rst_duty", 32'(duty_out), 32'd0);
    check("mid_rst_period", 32'(period_out), 32'd0);
    check("mid_rst_flags", 32'({duty_valid, stuck_low, stuck_high}), 32'd0);
    seen_d.delete();
    seen_p.delete();
    for (int i = 200; i < 256; i++) step(1'b1, 1'b0);
    gen(128, 256, 1);
    check("mid_rst_none_yet", 32'(seen_d.size()), 32'd0);
    gen(128, 256, 1);
    trail();
    check("mid_rst_count", 32'(seen_d.size()), 32'd2);
    check("mid_rst_first_duty", 32'(q_at(0, 0)), 32'd128);
    check("mid_rst_first_period", 32'(q_at(0, 1)), 32'd256);

    // Random generator settings
    for (int r = 0; r < 6; r++) begin
      int d;
      int pl;
      d  = int'($urandom_range(1, 200));
      pl = int'($urandom_range(32'(d + 1), 32'(d + 250)));
      pwm_in = 1'b0;
      do_reset();
      gen(d, pl, 2);
      trail();
      check("rnd_count", 32'(seen_d.size()), 32'd2);
      check("rnd_duty", 32'(q_at(1, 0)), 32'(d));
      check("rnd_period", 32'(q_at(1, 1)), 32'((pl > P) ? P : pl));
    end

    // Random run-length waveform with occasional resets
    pwm_in = 1'b0;
    do_reset();
    begin
      logic lvl;
      lvl = 1'b0;
      for (int r = 0; r < 60; r++) begin
        int len;
        if ($urandom_range(0, 3) == 0) len = int'($urandom_range(200, 300));
        else len = int'($urandom_range(1, 40));
        for (int i = 0; i < len; i++) step(1'b1, lvl);
        lvl = ~lvl;
        if ($urandom_range(0, 15) == 0) begin
          step(1'b0, lvl);
          step(1'b0, lvl);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the duty resolution in bits; the nominal PWM period is 2**n clock cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port pwm_in, input, 1 bit: asynchronous PWM waveform to be decoded.
REQ-005 The block SHALL have port duty_out, output, n bits: last measured high time in cycles.
REQ-006 The block SHALL have port period_out, output, n+1 bits: last measured rise-to-rise period in cycles.
REQ-007 The block SHALL have port duty_valid, output, 1 bit: one-cycle pulse when duty_out/period_out update.
REQ-008 The block SHALL have port stuck_low, output, 1 bit: level, input low for at least 2**n cycles.
REQ-009 The block SHALL have port stuck_high, output, 1 bit: level, input high for at least 2**n cycles.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal against a third registered copy, giving rise/fall detection 3 clk cycles after the input transition.
REQ-011 The FSM SHALL have states IDLE (wait for first rise, partial period discarded), HIGH and LOW.
REQ-012 Transitions SHALL be: IDLE->HIGH on rise; HIGH->LOW on fall; LOW->HIGH on rise; any other cycle holds state.
REQ-013 The cycle in which a rise is detected SHALL count as cycle 1 of a new period: period counter and high counter load 1.
REQ-014 In HIGH, high and period counters SHALL each increment by 1 per cycle; in LOW, only the period counter SHALL increment.
REQ-015 On a rise detected in LOW, the block SHALL register duty_out=high count (low n bits), period_out=period count, and assert duty_valid for exactly the following cycle.
REQ-016 The rise leaving IDLE SHALL NOT assert duty_valid.
REQ-017 Counters SHALL be n+1 bits and saturate at 2**n; no wrap-around.
REQ-018 A low-time counter SHALL count consecutive synchronized-low cycles in IDLE or LOW; on reaching 2**n, stuck_low SHALL set, duty_out SHALL load 0, period_out SHALL load 2**n, and duty_valid SHALL pulse once.
REQ-019 stuck_low SHALL remain set with no further duty_valid pulses until the next rise, which clears it and enters HIGH without a duty_valid.
REQ-020 When the high count reaches 2**n in HIGH, stuck_high SHALL set with no duty_valid; the next fall SHALL enter LOW and the following rise SHALL clear stuck_high without a duty_valid (measurement invalid).
REQ-021 A fall and rise within one period SHALL be handled in order; a one-cycle synchronized pulse SHALL produce a high count of 1.
REQ-022 For input from a 2**n-cycle generator with duty D (0<D<2**n), steady state SHALL give duty_out=D, period_out=2**n.

Reset
REQ-023 With reset low at a clk edge: state=IDLE, all counters 0, synchronizer flops 0, duty_out=0, period_out=0, duty_valid=0, stuck_low=0, stuck_high=0.
REQ-024 Reset mid-measurement SHALL discard the partial period; no duty_valid SHALL occur until one complete rise-to-rise period after reset release.

Structure
REQ-025 A shared package pwm_pkg SHALL hold the default width constant (8) and the FSM state encoding type.
REQ-026 A sub-module pwm_sync_edge SHALL contain the synchronizer and rise/fall detector; pwm_capture instantiates it once.

Verification (n=8, 10 ns clk)
REQ-027 Generator duty 64 -> from the second period on, duty_valid every 256 cycles, duty_out=64, period_out=256.
REQ-028 Duty change 128 -> 192 at a period boundary -> first full period after the change reports 192; no intermediate value.
REQ-029 pwm_in held 0 after reset -> 256 cycles after sync, stuck_low=1, one duty_valid with duty_out=0, period_out=256; none after.
REQ-030 pwm_in held 1 for 300 cycles, then normal duty 64 -> stuck_high=1, no duty_valid; cleared at the second rise, then duty_out=64.
REQ-031 reset pulsed low mid-HIGH at duty 128 -> all outputs 0; first duty_valid after release follows one full period and reports 128.
REQ-032 Single-cycle high pulses every 256 cycles -> duty_out=1, period_out=256.
